// File: rtl/panda_risc_v_tohost_mon.sv
`default_nettype none
// ==========================================================================
// panda_risc_v_tohost_mon: passive riscv-tests tohost completion monitor
// snooping AXI AW/W. Optional perf snapshot macro: TOHOST_MON_PERF_EN.
// Revision: 1.0
// ==========================================================================
module panda_risc_v_tohost_mon #(
    parameter int          TOHOST_CHN_N = 1,
    parameter logic [31:0] TOHOST_ADDR0 = 32'h3000,
    parameter logic [31:0] TOHOST_ADDR1 = 32'h3000,
    parameter logic [31:0] TOHOST_ADDR2 = 32'h3000,
    parameter logic [31:0] TOHOST_ADDR3 = 32'h3000,
    parameter int          DATA_WIDTH   = 32,
    parameter int          PEND_DEPTH   = 4,
    parameter int          TIMEOUT_TH   = 0,
    parameter int          SIM_DELAY    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             s_awaddr,
    input  logic                    s_awvalid,
    input  logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    input  logic                    s_wready,
    input  logic [31:0]             mcycle_i,
    input  logic [31:0]             minstret_i,
    output logic                    test_done,
    output logic                    test_pass,
    output logic                    test_timeout,
    output logic [30:0]             fail_testnum,
    output logic [1:0]              hit_chn,
    output logic                    snoop_ovf,
    output logic [31:0]             done_mcycle,
    output logic [31:0]             done_minstret
);

    localparam int PTR_W = $clog2(PEND_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = (TIMEOUT_TH == 0) ? 1 : $clog2(TIMEOUT_TH + 1);
    localparam logic [3:0][31:0] TOHOST_ADDRS =
        {TOHOST_ADDR3, TOHOST_ADDR2, TOHOST_ADDR1, TOHOST_ADDR0};

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DONE = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [3:0]       addr_match;
    logic             aw_hit;
    logic [1:0]       aw_chn;
    logic [31:0]      w_masked;
    logic [2:0]       aw_mem [PEND_DEPTH];
    logic [31:0]      w_mem  [PEND_DEPTH];
    logic [PTR_W-1:0] aw_wp, aw_rp, w_wp, w_rp;
    logic [CNT_W-1:0] aw_cnt, w_cnt;
    logic             aw_hs, w_hs, aw_full, w_full, aw_push, w_push, pop, drop;
    logic [2:0]       head_aw;
    logic [31:0]      head_data;
    logic             pair_hit, wd_expire, finish;
    logic             pass_nxt, tmo_nxt;
    logic [30:0]      tnum_nxt;
    logic [1:0]       chn_nxt;
    logic             unused_bits;

    for (genvar i = 0; i < 4; i++) begin : g_cmp
        if (i < TOHOST_CHN_N) begin : g_on
            assign addr_match[i] = (s_awaddr == TOHOST_ADDRS[i]);
        end else begin : g_off
            assign addr_match[i] = 1'b0;
        end
    end

    assign aw_hit = |addr_match;

    // Descending scan so the lowest matching comparator index wins.
    always_comb begin
        aw_chn = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (addr_match[i]) aw_chn = 2'(i);
        end
    end

    always_comb begin
        w_masked = 32'd0;
        for (int b = 0; b < 4; b++) begin
            if (s_wstrb[b]) w_masked[b*8 +: 8] = s_wdata[b*8 +: 8];
        end
    end

    assign aw_hs   = s_awvalid & s_awready;
    assign w_hs    = s_wvalid & s_wready;
    assign pop     = (aw_cnt != '0) && (w_cnt != '0);
    assign aw_full = (aw_cnt == CNT_W'(PEND_DEPTH));
    assign w_full  = (w_cnt == CNT_W'(PEND_DEPTH));
    // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted.
    assign aw_push = aw_hs && (!aw_full || pop);
    assign w_push  = w_hs && (!w_full || pop);
    assign drop    = (aw_hs && aw_full && !pop) || (w_hs && w_full && !pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_wp     <= '0;
            aw_rp     <= '0;
            w_wp      <= '0;
            w_rp      <= '0;
            aw_cnt    <= '0;
            w_cnt     <= '0;
            snoop_ovf <= 1'b0;
            for (int i = 0; i < PEND_DEPTH; i++) begin
                aw_mem[i] <= '0;
                w_mem[i]  <= '0;
            end
        end else begin
            if (aw_push) begin
                aw_mem[aw_wp] <= {aw_hit, aw_chn};
                aw_wp         <= aw_wp + 1'b1;
            end
            if (w_push) begin
                w_mem[w_wp] <= w_masked;
                w_wp        <= w_wp + 1'b1;
            end
            if (pop) begin
                aw_rp <= aw_rp + 1'b1;
                w_rp  <= w_rp + 1'b1;
            end
            aw_cnt <= aw_cnt + CNT_W'(aw_push) - CNT_W'(pop);
            w_cnt  <= w_cnt + CNT_W'(w_push) - CNT_W'(pop);
            if (drop) snoop_ovf <= 1'b1;
        end
    end

    assign head_aw   = aw_mem[aw_rp];
    assign head_data = w_mem[w_rp];
    assign pair_hit  = pop && head_aw[2] && (head_data != 32'd0);

    if (TIMEOUT_TH != 0) begin : g_wd
        logic [WD_W-1:0] wd_cnt;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wd_cnt <= '0;
            end else if ((state == ST_RUN) && (wd_cnt != {WD_W{1'b1}})) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
        assign wd_expire = (state == ST_RUN) && (wd_cnt == WD_W'(TIMEOUT_TH - 1));
    end else begin : g_no_wd
        assign wd_expire = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            test_done    <= 1'b0;
            test_pass    <= 1'b0;
            test_timeout <= 1'b0;
            fail_testnum <= '0;
            hit_chn      <= '0;
        end else begin
            state        <= state_nxt;
            test_done    <= test_done | finish;
            test_pass    <= pass_nxt;
            test_timeout <= tmo_nxt;
            fail_testnum <= tnum_nxt;
            hit_chn      <= chn_nxt;
        end
    end

    // A tohost hit takes precedence over a watchdog expiry in the same cycle.
    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        pass_nxt  = test_pass;
        tmo_nxt   = test_timeout;
        tnum_nxt  = fail_testnum;
        chn_nxt   = hit_chn;
        if (state == ST_RUN) begin
            if (pair_hit) begin
                state_nxt = ST_DONE;
                finish    = 1'b1;
                pass_nxt  = (head_data == 32'd1);
                tmo_nxt   = 1'b0;
                tnum_nxt  = (head_data == 32'd1) ? 31'd0 : head_data[31:1];
                chn_nxt   = head_aw[1:0];
            end else if (wd_expire) begin
                state_nxt = ST_DONE;
                finish    = 1'b1;
                pass_nxt  = 1'b0;
                tmo_nxt   = 1'b1;
                tnum_nxt  = 31'd0;
            end
        end
    end

`ifdef TOHOST_MON_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_mcycle   <= '0;
            done_minstret <= '0;
        end else if (finish) begin
            done_mcycle   <= mcycle_i;
            done_minstret <= minstret_i;
        end
    end
    assign unused_bits = ^{s_wdata, s_wstrb, (SIM_DELAY != 0)};
`else
    assign done_mcycle   = 32'd0;
    assign done_minstret = 32'd0;
    assign unused_bits   = ^{s_wdata, s_wstrb, mcycle_i, minstret_i, (SIM_DELAY != 0)};
`endif

endmodule
`default_nettype wire

// File: tb/tb_panda_risc_v_tohost_mon.sv
`default_nettype none
// tb_panda_risc_v_tohost_mon: scoreboard bench; randomized AW/W schedules are
// decoded by a pairing/decoding model and compared on every test_done rise.
module tb_panda_risc_v_tohost_mon;

    localparam int TH = 200;
    localparam int NE = 256;
    localparam logic [31:0] A0 = 32'h3000;
    localparam logic [31:0] A1 = 32'h4000;
    localparam logic [31:0] A2 = 32'h5000;
    localparam logic [31:0] A3 = 32'h6000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_awaddr = '0;
    logic        s_awvalid = 1'b0, s_awready = 1'b0;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0, s_wready = 1'b0;
    logic [31:0] mcycle_i = '0, minstret_i = '0;
    logic        test_done, test_pass, test_timeout, snoop_ovf;
    logic [30:0] fail_testnum;
    logic [1:0]  hit_chn;
    logic [31:0] done_mcycle, done_minstret;

    always #5 clk = ~clk;

    panda_risc_v_tohost_mon #(
        .TOHOST_CHN_N(2), .TOHOST_ADDR0(A0), .TOHOST_ADDR1(A1),
        .TOHOST_ADDR2(A2), .TOHOST_ADDR3(A3), .DATA_WIDTH(32),
        .PEND_DEPTH(2), .TIMEOUT_TH(TH), .SIM_DELAY(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .mcycle_i(mcycle_i), .minstret_i(minstret_i),
        .test_done(test_done), .test_pass(test_pass), .test_timeout(test_timeout),
        .fail_testnum(fail_testnum), .hit_chn(hit_chn), .snoop_ovf(snoop_ovf),
        .done_mcycle(done_mcycle), .done_minstret(done_minstret)
    );

    typedef struct { bit pass; bit tmo; logic [30:0] tnum; logic [1:0] chn; int done_at; } exp_t;
    typedef struct { int at; logic [31:0] addr; } aw_t;
    typedef struct { int at; logic [31:0] data; logic [3:0] strb; } w_t;

    exp_t sb[$];
    exp_t last_exp;
    aw_t  aw_q[$];
    w_t   w_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   prev_done = 1'b0;

    bit          aw_ev[NE];
    logic [31:0] aw_ev_addr[NE];
    bit          w_ev[NE];
    logic [31:0] w_ev_data[NE];
    logic [3:0]  w_ev_strb[NE];

    // Edge index since reset release: after the n-th un-reset edge cyc == n.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && test_done && !prev_done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done at edge %0d, want no completion", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_edge", 64'(cyc), 64'(e.done_at));
                chk("test_pass", 64'(test_pass), 64'(e.pass));
                chk("test_timeout", 64'(test_timeout), 64'(e.tmo));
                chk("fail_testnum", 64'(fail_testnum), 64'(e.tnum));
                chk("hit_chn", 64'(hit_chn), 64'(e.chn));
`ifdef TOHOST_MON_PERF_EN
                chk("done_mcycle", 64'(done_mcycle), 64'(1000 + 3 * cyc));
                chk("done_minstret", 64'(done_minstret), 64'(500 + 7 * cyc));
`else
                chk("done_mcycle", 64'(done_mcycle), 64'd0);
                chk("done_minstret", 64'(done_minstret), 64'd0);
`endif
            end
        end
        prev_done <= test_done;
    end

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return A0;
            1:       return A1;
            2:       return A2;
            3:       return 32'h2000;
            default: return 32'h3004;
        endcase
    endfunction

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 3))
            0:       return 32'd1;
            1:       return 32'd0;
            2:       return 32'($urandom_range(2, 63));
            default: return $urandom;
        endcase
    endfunction

    task automatic clear_sched();
        for (int i = 0; i < NE; i++) begin
            aw_ev[i] = 1'b0;
            w_ev[i]  = 1'b0;
        end
        aw_q.delete();
        w_q.delete();
    endtask

    task automatic add_aw(input int at, input logic [31:0] addr);
        aw_ev[at] = 1'b1;
        aw_ev_addr[at] = addr;
        aw_q.push_back('{at, addr});
    endtask

    task automatic add_w(input int at, input logic [31:0] data, input logic [3:0] strb);
        w_ev[at] = 1'b1;
        w_ev_data[at] = data;
        w_ev_strb[at] = strb;
        w_q.push_back('{at, data, strb});
    endtask

    task automatic push_exp(input bit p, input bit t, input logic [30:0] n, input logic [1:0] c, input int at);
        exp_t e;
        e = '{p, t, n, c, at};
        sb.push_back(e);
        last_exp = e;
    endtask

    // Pair i completes one edge after both its halves and the previous pair are in.
    task automatic model_expect();
        int prev_pop = 0;
        int pop;
        int chn;
        logic [31:0] d;
        int n = (aw_q.size() < w_q.size()) ? aw_q.size() : w_q.size();
        for (int i = 0; i < n; i++) begin
            pop = aw_q[i].at;
            if (w_q[i].at > pop) pop = w_q[i].at;
            if (prev_pop > pop) pop = prev_pop;
            pop = pop + 1;
            prev_pop = pop;
            if (pop > TH) break;
            d = 32'd0;
            for (int b = 0; b < 4; b++)
                if (w_q[i].strb[b]) d = d | (w_q[i].data & (32'hFF << (8 * b)));
            chn = (aw_q[i].addr == A0) ? 0 : (aw_q[i].addr == A1) ? 1 : -1;
            if (chn >= 0 && d != 32'd0) begin
                push_exp(d == 32'd1, 1'b0, (d == 32'd1) ? 31'd0 : d[31:1], 2'(chn), pop);
                return;
            end
        end
        push_exp(1'b0, 1'b1, 31'd0, 2'd0, TH);
    endtask

    task automatic run_sched(input int first, input int last);
        for (int e = first; e <= last; e++) begin
            mcycle_i   = 32'(1000 + 3 * e);
            minstret_i = 32'(500 + 7 * e);
            if (e < NE && aw_ev[e]) begin
                {s_awvalid, s_awready} = 2'b11;
                s_awaddr = aw_ev_addr[e];
            end else begin
                case ($urandom_range(0, 2))
                    0:       {s_awvalid, s_awready} = 2'b00;
                    1:       {s_awvalid, s_awready} = 2'b10;
                    default: {s_awvalid, s_awready} = 2'b01;
                endcase
                s_awaddr = pick_addr();
            end
            if (e < NE && w_ev[e]) begin
                {s_wvalid, s_wready} = 2'b11;
                s_wdata = w_ev_data[e];
                s_wstrb = w_ev_strb[e];
            end else begin
                case ($urandom_range(0, 2))
                    0:       {s_wvalid, s_wready} = 2'b00;
                    1:       {s_wvalid, s_wready} = 2'b10;
                    default: {s_wvalid, s_wready} = 2'b01;
                endcase
                s_wdata = 32'd1;
                s_wstrb = 4'hF;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {s_awvalid, s_awready, s_wvalid, s_wready} = 4'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset();
        chk("rst_done", 64'(test_done), 64'd0);
        chk("rst_pass", 64'(test_pass), 64'd0);
        chk("rst_timeout", 64'(test_timeout), 64'd0);
        chk("rst_testnum", 64'(fail_testnum), 64'd0);
        chk("rst_chn", 64'(hit_chn), 64'd0);
        chk("rst_ovf", 64'(snoop_ovf), 64'd0);
        chk("rst_mcycle", 64'(done_mcycle), 64'd0);
    endtask

    // After completion the results must stay frozen while the bus keeps toggling.
    task automatic end_check();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        sb.delete();
        chk("hold_done", 64'(test_done), 64'd1);
        chk("hold_pass", 64'(test_pass), 64'(last_exp.pass));
        chk("hold_timeout", 64'(test_timeout), 64'(last_exp.tmo));
        chk("hold_testnum", 64'(fail_testnum), 64'(last_exp.tnum));
        chk("hold_chn", 64'(hit_chn), 64'(last_exp.chn));
        chk("no_ovf", 64'(snoop_ovf), 64'd0);
`ifdef TOHOST_MON_PERF_EN
        chk("hold_mcycle", 64'(done_mcycle), 64'(1000 + 3 * last_exp.done_at));
`endif
    endtask

    task automatic run_full();
        do_reset();
        check_reset();
        run_sched(1, TH + 5);
        end_check();
    endtask

    task automatic random_test();
        int base = 1;
        int nwr = int'($urandom_range(1, 8));
        int da, dw;
        clear_sched();
        for (int j = 0; j < nwr; j++) begin
            da = int'($urandom_range(0, 2));
            dw = int'($urandom_range(0, 2));
            add_aw(base + da, pick_addr());
            add_w(base + dw, pick_data(), ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom));
            base = base + ((da > dw) ? da : dw) + 1 + int'($urandom_range(0, 3));
        end
        model_expect();
        run_full();
    endtask

    initial begin
        @(negedge clk);

        // Same-cycle pass on channel 0.
        clear_sched(); add_aw(1, A0); add_w(1, 32'd1, 4'hF);
        push_exp(1'b1, 1'b0, 31'd0, 2'd0, 2); run_full();

        // W one cycle ahead of AW, fail code 0xB -> testnum 5.
        clear_sched(); add_w(3, 32'hB, 4'hF); add_aw(4, A0);
        push_exp(1'b0, 1'b0, 31'd5, 2'd0, 5); run_full();

        // Non-tohost write first, then pass on channel 1.
        clear_sched(); add_aw(2, 32'h2000); add_w(2, 32'd7, 4'hF); add_aw(4, A1); add_w(4, 32'd1, 4'hF);
        push_exp(1'b1, 1'b0, 31'd0, 2'd1, 5); run_full();

        // Inactive comparator, zero data after masking, then masked fail on channel 1.
        clear_sched();
        add_aw(1, A2); add_w(1, 32'd1, 4'hF);
        add_aw(2, A0); add_w(2, 32'hFFFF_FF00, 4'b0001);
        add_aw(3, A1); add_w(3, 32'hFFFF_07FF, 4'b0010);
        push_exp(1'b0, 1'b0, 31'h380, 2'd1, 4); run_full();

        // Watchdog alone, hit tying the watchdog, and hit one edge too late.
        clear_sched(); push_exp(1'b0, 1'b1, 31'd0, 2'd0, TH); run_full();
        clear_sched(); add_aw(TH - 1, A1); add_w(TH - 1, 32'd1, 4'hF);
        push_exp(1'b1, 1'b0, 31'd0, 2'd1, TH); run_full();
        clear_sched(); add_aw(TH, A0); add_w(TH, 32'd1, 4'hF);
        push_exp(1'b0, 1'b1, 31'd0, 2'd0, TH); run_full();

        // Overflow: three AWs into a depth-2 FIFO with W withheld.
        clear_sched(); add_aw(1, 32'h2000); add_aw(2, 32'h2000); add_aw(3, 32'h2000);
        do_reset(); check_reset();
        run_sched(1, 2); chk("ovf_before", 64'(snoop_ovf), 64'd0);
        run_sched(3, 3); chk("ovf_set", 64'(snoop_ovf), 64'd1);
        run_sched(4, 6); chk("ovf_sticky", 64'(snoop_ovf), 64'd1);

        // Third AW coinciding with a pop is accepted.
        clear_sched(); add_aw(1, 32'h2000); add_aw(2, 32'h2000); add_w(2, 32'd5, 4'hF); add_aw(3, 32'h2000);
        do_reset(); check_reset();
        run_sched(1, 4); chk("ovf_pop_coincide", 64'(snoop_ovf), 64'd0);

        // Reset mid-pairing discards the stale tohost AW.
        clear_sched(); add_aw(1, A0);
        do_reset(); run_sched(1, 2);
        clear_sched(); add_w(1, 32'd1, 4'hF); add_aw(2, 32'h2000); add_aw(3, A0); add_w(3, 32'd9, 4'hF);
        push_exp(1'b0, 1'b0, 31'd4, 2'd0, 4); run_full();

        for (int t = 0; t < 12; t++) random_test();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
